// File: rtl/cla_seq_pkg.sv
// -----------------------------------------------------------------------------
// cla_seq_pkg
// Shared definitions for the serial carry-lookahead adder sequencer:
//   - state_t : sequencer state encoding (IDLE, RUN, DONE_S)
//   - SLICE_W : number of bits consumed per step by the lookahead slice
//   - clog2() : width of the step counter for a given step count
// Optional feature macro used by the sequencer: CLA_SEQ_OVF_EN.
// -----------------------------------------------------------------------------
package cla_seq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      DONE_S = 2'd2
   } state_t;

   localparam int SLICE_W = 2;

   // Ceiling log2, never less than 1 so a counter always has at least one bit.
   function automatic int clog2(input int v);
      int r;
      int x;
      r = 0;
      x = v - 1;
      while (x > 0) begin
         r = r + 1;
         x = x >> 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/cla_slice2.sv
// -----------------------------------------------------------------------------
// cla_slice2
// Purely combinational 2-bit carry-lookahead slice built from generate and
// propagate terms.
// Ports:
//   a[1:0], b[1:0] : operand bits
//   cin            : carry into bit 0
//   sum[1:0]       : slice sum
//   cout           : carry out of bit 1
// -----------------------------------------------------------------------------
module cla_slice2 (
   input  logic [1:0] a,
   input  logic [1:0] b,
   input  logic       cin,
   output logic [1:0] sum,
   output logic       cout
);

   logic g0, g1, p0, p1, c1;

   assign g0 = a[0] & b[0];
   assign g1 = a[1] & b[1];
   assign p0 = a[0] ^ b[0];
   assign p1 = a[1] ^ b[1];

   // Both carries are formed directly from g/p and cin, no ripple.
   assign c1     = g0 | (p0 & cin);
   assign cout   = g1 | (p1 & g0) | (p1 & p0 & cin);
   assign sum[0] = p0 ^ cin;
   assign sum[1] = p1 ^ c1;

endmodule

// File: rtl/cla_serial_sequencer.sv
// -----------------------------------------------------------------------------
// cla_serial_sequencer
// Performs a WIDTH-bit addition {cout,sum} = a + b + cin by stepping a single
// 2-bit lookahead slice (cla_slice2) over the operands, LSB first, with a
// registered carry linking the steps. One add takes WIDTH/2 step cycles.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, accepted in IDLE or DONE_S
//   a, b, cin  : operands, captured on the accept edge
//   busy       : high while steps are in progress
//   done       : one-cycle pulse when sum/cout are updated
//   sum, cout  : result, held until the next completion
//   ovf        : signed overflow, present only when CLA_SEQ_OVF_EN is defined
// -----------------------------------------------------------------------------
module cla_serial_sequencer
   import cla_seq_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
`ifdef CLA_SEQ_OVF_EN
   output logic             ovf,
`endif
   output logic             cout
);

   localparam int N  = WIDTH / SLICE_W;
   localparam int CW = clog2(N);
   localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] psum;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             accept;

   logic [SLICE_W-1:0] slice_sum;
   logic               slice_cout;
   logic [WIDTH-1:0]   psum_next;

`ifdef CLA_SEQ_OVF_EN
   logic a_msb;
   logic b_msb;
`endif

   cla_slice2 u_slice (
      .a    (a_sh[SLICE_W-1:0]),
      .b    (b_sh[SLICE_W-1:0]),
      .cin  (carry),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   // New slice bits enter at the top; after N steps the LSB slice has
   // travelled down to bit 0 and the partial sum is complete.
   assign psum_next = {slice_sum, psum[WIDTH-1:SLICE_W]};
   assign accept    = start && ((state == IDLE) || (state == DONE_S));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         a_sh  <= '0;
         b_sh  <= '0;
         psum  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
         ovf   <= 1'b0;
         a_msb <= 1'b0;
         b_msb <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE_S: begin
               if (accept) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  carry <= cin;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
`ifdef CLA_SEQ_OVF_EN
                  a_msb <= a[WIDTH-1];
                  b_msb <= b[WIDTH-1];
`endif
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end

            RUN: begin
               // start is deliberately ignored here: no queuing of requests.
               a_sh  <= a_sh >> SLICE_W;
               b_sh  <= b_sh >> SLICE_W;
               psum  <= psum_next;
               carry <= slice_cout;
               cnt   <= cnt + 1'b1;
               if (cnt == LAST_STEP) begin
                  sum   <= psum_next;
                  cout  <= slice_cout;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= DONE_S;
`ifdef CLA_SEQ_OVF_EN
                  // Carry into the MSB is a^b^sum there; xor with carry out.
                  ovf   <= a_msb ^ b_msb ^ slice_sum[SLICE_W-1] ^ slice_cout;
`endif
               end
            end

            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cla_serial_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cla_serial_sequencer
// Self-checking bench for cla_serial_sequencer (WIDTH=16). Directed cases plus
// randomized operands, compared with a plain-arithmetic reference model.
// Optional feature macro: CLA_SEQ_OVF_EN (enables ovf checks).
// -----------------------------------------------------------------------------
module tb_cla_serial_sequencer;

   localparam int WIDTH = 16;
   localparam int N     = WIDTH / 2;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef CLA_SEQ_OVF_EN
   logic             ovf;
`endif

   int n_cmp = 0;
   int n_err = 0;

   // Last completed result, which the DUT must hold between completions.
   logic [WIDTH-1:0] exp_sum  = '0;
   logic             exp_cout = 1'b0;
   logic             exp_ovf  = 1'b0;

   cla_serial_sequencer #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
`ifdef CLA_SEQ_OVF_EN
      .ovf   (ovf),
`endif
      .cout  (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain (WIDTH+1)-bit addition.
   function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                              input logic c);
      return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
   endfunction

   // Reference: signed overflow when both operands share a sign the result lacks.
   function automatic logic ref_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                    input logic [WIDTH-1:0] s);
      return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
   endfunction

   task automatic check_result(input string tag);
      check({tag, "_sum"},  32'(sum),  32'(exp_sum));
      check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
`ifdef CLA_SEQ_OVF_EN
      check({tag, "_ovf"},  32'(ovf),  32'(exp_ovf));
`endif
   endtask

   // Present operands with start high and take the accept edge. Inputs are
   // then scrambled to prove they were captured; start stays high if hold.
   task automatic launch(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob, input logic oc,
                         input bit hold);
      a     = oa;
      b     = ob;
      cin   = oc;
      start = 1'b1;
      @(posedge clk); #1;
      a     = 16'($urandom);
      b     = 16'($urandom);
      cin   = 1'($urandom);
      start = hold;
      check("busy_after_accept", 32'(busy), 32'd1);
      check("done_after_accept", 32'(done), 32'd0);
      check_result("held_in_run");
   endtask

   // Wait (bounded) for done after a launch; check latency, busy length and
   // result. poke>0 pulses start with junk operands during that step.
   task automatic finish_op(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob, input logic oc,
                            input int poke, input bit hold, input string tag);
      logic [WIDTH:0] r;
      int edges;
      int bcnt;
      r     = ref_add(oa, ob, oc);
      edges = 1;
      bcnt  = busy ? 1 : 0;
      while (!done && edges < 40) begin
         if (edges == poke) begin
            start = 1'b1;
            a     = 16'hAAAA;
            b     = 16'($urandom);
         end else begin
            start = hold;
         end
         @(posedge clk); #1;
         edges++;
         if (busy) bcnt++;
      end
      check({tag, "_done_seen"}, 32'(done), 32'd1);
      check({tag, "_latency"},   32'(edges), 32'(N + 1));
      check({tag, "_busy_cycles"}, 32'(bcnt), 32'(N));
      check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
      exp_sum  = r[WIDTH-1:0];
      exp_cout = r[WIDTH];
      exp_ovf  = ref_ovf(oa, ob, r[WIDTH-1:0]);
      check_result(tag);
   endtask

   // Idle for n cycles with start low; done must stay low and results held.
   task automatic idle_watch(input int n, input string tag);
      int dones;
      dones = 0;
      start = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         if (done || busy) dones++;
      end
      check({tag, "_quiet"}, 32'(dones), 32'd0);
      check_result({tag, "_held"});
   endtask

   task automatic full_op(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob, input logic oc,
                          input int poke, input string tag);
      launch(oa, ob, oc, 1'b0);
      finish_op(oa, ob, oc, poke, 1'b0, tag);
      idle_watch((poke > 0) ? 12 : 1, tag);
   endtask

   initial begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      logic             rc;
      int               rp;

      // Reset with unknown inputs.
      rst_n = 1'b0;
      start = 1'bx;
      a     = 'x;
      b     = 'x;
      cin   = 1'bx;
      #23;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check_result("rst");
      start = 1'b0;
      a     = '0;
      b     = '0;
      cin   = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);

      // Directed cases.
      full_op(16'h1234, 16'h4321, 1'b0, 0, "basic");
      full_op(16'hFFFF, 16'h0000, 1'b1, 0, "carry_chain");
      full_op(16'hFFFF, 16'hFFFF, 1'b1, 0, "all_ones");
      full_op(16'h8000, 16'h8000, 1'b0, 0, "neg_ovf");
      full_op(16'h0001, 16'h0001, 1'b0, 3, "busy_reject");

      // Asynchronous reset in the middle of a run.
      launch(16'h5A5A, 16'h1111, 1'b1, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      exp_sum  = '0;
      exp_cout = 1'b0;
      exp_ovf  = 1'b0;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check_result("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      idle_watch(3, "after_rst");
      full_op(16'h00FF, 16'h0001, 1'b0, 0, "post_rst");

      // Back-to-back: start held through the DONE cycle.
      launch(16'h7FFF, 16'h0001, 1'b0, 1'b1);
      finish_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b1, "b2b_first");
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      a  = ra;
      b  = rb;
      cin = rc;
      @(posedge clk); #1;
      start = 1'b0;
      a     = 16'($urandom);
      check("b2b_accept_busy", 32'(busy), 32'd1);
      check("b2b_done_pulse", 32'(done), 32'd0);
      finish_op(ra, rb, rc, 0, 1'b0, "b2b_second");
      idle_watch(1, "b2b_second");

      // Randomized operands, occasionally with a rejected mid-run start.
      for (int i = 0; i < 24; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom);
         rp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, N - 1)) : 0;
         full_op(ra, rb, rc, rp, "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
